// File: rtl/arbiter_n2_requester.sv
`default_nettype none
// ============================================================================
// Module      : arbiter_n2_requester
// Description : Requester agent for one port of a 2-requester arbiter.
//               Queues burst jobs, requests the port and runs granted bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module arbiter_n2_requester #(
    parameter int DEPTH   = 4,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       job_valid,
    input  logic [LEN_W-1:0]           job_len,
    output logic                       job_ready,
    output logic                       req,
    input  logic                       gnt,
    output logic                       beat_valid,
    output logic                       beat_last,
    output logic [$clog2(DEPTH):0]     pending,
    output logic                       starve_err,
    output logic                       proto_err
);

    localparam int c_AW     = $clog2(DEPTH);
    localparam int c_CNT_W  = $clog2(DEPTH) + 1;
    localparam int c_WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [LEN_W-1:0]     r_mem [DEPTH];
    logic [c_AW-1:0]      r_wr_ptr;
    logic [c_AW-1:0]      r_rd_ptr;
    logic [c_CNT_W-1:0]   r_pending;
    logic [LEN_W-1:0]     r_beat_cnt;
    logic [c_WAIT_W-1:0]  r_wait_cnt;
    logic                 r_starve_err;
    logic                 r_proto_err;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_req;
    logic                 w_beat_valid;
    logic                 w_beat_last;
    logic                 w_job_ready;

    // No bypass: a full queue refuses even while the head is being popped.
    assign w_job_ready = (r_pending != c_CNT_W'(DEPTH));
    assign w_push      = job_valid && w_job_ready;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_req        = 1'b0;
        w_beat_valid = 1'b0;
        w_beat_last  = 1'b0;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pending != '0) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                w_req = 1'b1;
                if (gnt) begin
                    w_state_nxt = S_XFER;
                    w_pop       = 1'b1;
                end
            end
            S_XFER: begin
                w_req        = 1'b1;
                w_beat_valid = 1'b1;
                w_beat_last  = (r_beat_cnt == '0);
                // A dropped grant abandons the rest of the burst.
                if (!gnt || (r_beat_cnt == '0)) begin
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Job queue
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= job_len;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_pending <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_pending <= r_pending + c_CNT_W'(1);
                2'b01:   r_pending <= r_pending - c_CNT_W'(1);
                default: r_pending <= r_pending;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Beat counter, watchdog and sticky error flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat_cnt <= '0;
        end else if (w_pop) begin
            r_beat_cnt <= r_mem[r_rd_ptr];
        end else if ((r_state == S_XFER) && gnt && (r_beat_cnt != '0)) begin
            r_beat_cnt <= r_beat_cnt - LEN_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if ((r_state == S_IDLE) && (w_state_nxt == S_REQ)) begin
            r_wait_cnt <= '0;
        end else if ((r_state == S_REQ) && !gnt &&
                     (r_wait_cnt != c_WAIT_W'(TIMEOUT))) begin
            r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_err <= 1'b0;
            r_proto_err  <= 1'b0;
        end else begin
            if ((r_state == S_REQ) && !gnt &&
                (r_wait_cnt == c_WAIT_W'(TIMEOUT - 1))) begin
                r_starve_err <= 1'b1;
            end
            if ((r_state == S_XFER) && !gnt) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign job_ready  = w_job_ready;
    assign req        = w_req;
    assign beat_valid = w_beat_valid;
    assign beat_last  = w_beat_last;
    assign pending    = r_pending;
    assign starve_err = r_starve_err;
    assign proto_err  = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_arbiter_n2_requester.sv
`default_nettype none
// ============================================================================
// Module      : tb_arbiter_n2_requester
// Description : Self-checking bench for arbiter_n2_requester against a
//               job-queue / burst-schedule model, plus directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arbiter_n2_requester;

    localparam int c_DEPTH   = 4;
    localparam int c_LEN_W   = 4;
    localparam int c_TIMEOUT = 16;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       job_valid = 1'b0;
    logic [c_LEN_W-1:0]         job_len = '0;
    logic                       job_ready;
    logic                       req;
    logic                       gnt = 1'b0;
    logic                       beat_valid;
    logic                       beat_last;
    logic [$clog2(c_DEPTH):0]   pending;
    logic                       starve_err;
    logic                       proto_err;

    int n_vec  = 0;
    int n_miss = 0;

    arbiter_n2_requester #(
        .DEPTH   (c_DEPTH),
        .LEN_W   (c_LEN_W),
        .TIMEOUT (c_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .job_valid  (job_valid),
        .job_len    (job_len),
        .job_ready  (job_ready),
        .req        (req),
        .gnt        (gnt),
        .beat_valid (beat_valid),
        .beat_last  (beat_last),
        .pending    (pending),
        .starve_err (starve_err),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    // Model: queue of job lengths; m_busy = requesting, m_beats = beats still
    // to present (current one included), m_gap = the enforced release cycle.
    int q[$];
    bit m_busy;
    int m_beats;
    bit m_gap;
    int m_wait;
    bit m_starve;
    bit m_proto;

    task automatic model_reset();
        q.delete();
        m_busy   = 1'b0;
        m_beats  = 0;
        m_gap    = 1'b0;
        m_wait   = 0;
        m_starve = 1'b0;
        m_proto  = 1'b0;
    endtask

    task automatic model_edge();
        int  old_size;
        bit  push;
        if (rst) begin
            model_reset();
        end else begin
            old_size = q.size();
            push     = job_valid && (old_size != c_DEPTH);
            if (m_beats > 0) begin
                if (gnt) begin
                    m_beats--;
                    if (m_beats == 0) m_gap = 1'b1;
                end else begin
                    m_proto = 1'b1;
                    m_beats = 0;
                    m_gap   = 1'b1;
                end
            end else if (m_busy) begin
                if (gnt) begin
                    m_beats = q.pop_front() + 1;
                    m_busy  = 1'b0;
                end else begin
                    m_wait++;
                    if (m_wait == c_TIMEOUT) m_starve = 1'b1;
                end
            end else if (m_gap) begin
                m_gap = 1'b0;
            end else if (old_size != 0) begin
                m_busy = 1'b1;
                m_wait = 0;
            end
            if (push) q.push_back(int'(job_len));
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("req",        32'(req),        32'(m_busy || (m_beats > 0)));
        chk("beat_valid", 32'(beat_valid), 32'(m_beats > 0));
        chk("beat_last",  32'(beat_last),  32'(m_beats == 1));
        chk("pending",    32'(pending),    32'(q.size()));
        chk("job_ready",  32'(job_ready),  32'(q.size() != c_DEPTH));
        chk("starve_err", 32'(starve_err), 32'(m_starve));
        chk("proto_err",  32'(proto_err),  32'(m_proto));
    endtask

    // One clock: model follows the edge, outputs compared mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        job_valid = 1'b0;
        gnt       = 1'b0;
        #1;
        model_reset();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench timeout");
    end

    initial begin
        int  nb;
        int  last_mask;
        int  low_between;
        bit  prev_req;
        bit  seen_beat;
        int  pend_low;

        model_reset();
        tick();
        rst = 1'b0;
        chk("reset_pending",   32'(pending),   0);
        chk("reset_job_ready", 32'(job_ready), 1);
        chk("reset_req",       32'(req),       0);

        // Single short burst
        job_valid = 1'b1; job_len = 4'd0; gnt = 1'b0;
        tick();
        job_valid = 1'b0;
        chk("single_pending1", 32'(pending), 1);
        chk("single_req_idle", 32'(req), 0);
        tick();
        chk("single_req_on", 32'(req), 1);
        gnt = 1'b1;
        tick();
        chk("single_beat",     32'(beat_valid), 1);
        chk("single_last",     32'(beat_last),  1);
        chk("single_pending0", 32'(pending),    0);
        tick();
        chk("single_gap_req",  32'(req),        0);
        chk("single_gap_beat", 32'(beat_valid), 0);
        gnt = 1'b0;
        tick();
        tick();

        // Back-to-back jobs, grant follows req one cycle late
        job_valid = 1'b1; job_len = 4'd2;
        tick();
        job_len = 4'd3;
        tick();
        job_valid = 1'b0;
        nb = 0; last_mask = 0; low_between = 0; prev_req = req; seen_beat = 1'b0;
        for (int i = 0; i < 20; i++) begin
            gnt      = prev_req;
            prev_req = req;
            tick();
            if (beat_valid) begin
                nb++;
                seen_beat = 1'b1;
                if (beat_last) last_mask |= (1 << nb);
            end else if (seen_beat && !req && nb < 7) begin
                low_between++;
            end
        end
        chk("b2b_beats",     32'(nb),          7);
        chk("b2b_last_mask", 32'(last_mask),   32'((1 << 3) | (1 << 7)));
        chk("b2b_req_low",   32'(low_between), 2);
        gnt = 1'b0;

        // FIFO full
        do_reset();
        gnt = 1'b0; job_valid = 1'b1; job_len = 4'd1;
        repeat (4) tick();
        chk("full_pending4", 32'(pending),   4);
        chk("full_ready0",   32'(job_ready), 0);
        tick();
        chk("full_5th_refused", 32'(pending), 4);
        gnt = 1'b1;
        tick();
        chk("full_pop_pending3", 32'(pending),   3);
        chk("full_pop_ready1",   32'(job_ready), 1);
        tick();
        chk("full_5th_accepted", 32'(pending), 4);
        job_valid = 1'b0;
        repeat (30) tick();
        chk("full_drained", 32'(pending), 0);

        // Starvation
        do_reset();
        job_valid = 1'b1; job_len = 4'd1; gnt = 1'b0;
        tick();
        job_valid = 1'b0;
        tick();
        chk("starve_req_on", 32'(req), 1);
        repeat (15) tick();
        chk("starve_not_yet", 32'(starve_err), 0);
        tick();
        chk("starve_set",     32'(starve_err), 1);
        chk("starve_req_stay", 32'(req),       1);
        gnt = 1'b1;
        tick();
        chk("starve_burst", 32'(beat_valid), 1);
        tick();
        tick();
        chk("starve_sticky", 32'(starve_err), 1);
        gnt = 1'b0;

        // Grant dropped mid-burst
        do_reset();
        job_valid = 1'b1; job_len = 4'd3;
        tick();
        job_len = 4'd0;
        tick();
        job_valid = 1'b0; gnt = 1'b1;
        tick();
        tick();
        chk("drop_beat2", 32'(beat_valid), 1);
        gnt = 1'b0;
        tick();
        chk("drop_proto",    32'(proto_err),  1);
        chk("drop_beat_off", 32'(beat_valid), 0);
        chk("drop_gap_req",  32'(req),        0);
        gnt = 1'b1;
        tick();
        chk("drop_idle_req", 32'(req), 0);
        tick();
        tick();
        chk("drop_next_beat", 32'(beat_valid), 1);
        chk("drop_next_last", 32'(beat_last),  1);
        tick();

        // Reset mid-burst
        do_reset();
        job_valid = 1'b1; job_len = 4'd3; gnt = 1'b1;
        tick();
        tick();
        tick();
        job_valid = 1'b0;
        tick();
        chk("rstmid_beat",    32'(beat_valid), 1);
        chk("rstmid_pending", 32'(pending),    2);
        rst = 1'b1;
        #1;
        chk("rstmid_req",     32'(req),        0);
        chk("rstmid_bv",      32'(beat_valid), 0);
        chk("rstmid_bl",      32'(beat_last),  0);
        chk("rstmid_pend0",   32'(pending),    0);
        chk("rstmid_starve",  32'(starve_err), 0);
        chk("rstmid_proto",   32'(proto_err),  0);
        model_reset();
        tick();
        rst = 1'b0; gnt = 1'b0;
        chk("rstmid_ready", 32'(job_ready), 1);
        pend_low = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (!req) pend_low++;
        end
        chk("rstmid_no_req", 32'(pend_low), 4);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end
            job_valid = ($urandom_range(0, 2) == 0);
            job_len   = 4'($urandom_range(0, 6));
            if (m_beats > 0)
                gnt = ($urandom_range(0, 19) != 0);
            else if (m_busy)
                gnt = (((i / 150) % 5) == 4) ? 1'b0 : ($urandom_range(0, 3) != 0);
            else
                gnt = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arbiter_n2_requester.md
# arbiter_n2_requester

Requester-side agent for one port of the 2-requester arbiter: queues transfer jobs from local logic, drives that port's `req`, waits for `gnt`, then runs the granted burst beat-by-beat. It releases `req` so the arbiter can return to IDLE. One instance sits on each arbiter port (bit 0 and bit 1 of the arbiter request/grant vectors). It also flags starvation and grant-protocol violations.

## Interface
- `DEPTH`, 4, job queue entries; power of 2, ≥2
- `LEN_W`, 4, job length field width; a burst is `job_len+1` beats
- `TIMEOUT`, 16, cycles of `req` high without `gnt` before `starve_err`; ≥2
- `clk` in 1 — single clock; all logic on posedge
- `rst` in 1 — reset, asynchronous and active-high
- `job_valid` in 1 — job offered
- `job_len` in LEN_W — beats minus one
- `job_ready` out 1 — queue can accept a job
- `req` out 1 — request to arbiter for this port
- `gnt` in 1 — grant from arbiter for this port
- `beat_valid` out 1 — burst beat in progress
- `beat_last` out 1 — final beat of the burst
- `pending` out $clog2(DEPTH)+1 — jobs queued, not yet granted
- `starve_err` out 1 — sticky starvation flag
- `proto_err` out 1 — sticky grant-dropped-mid-burst flag

## Operation
- **Job FIFO**
  - Push on `job_valid && job_ready`.
  - `job_ready = (pending != DEPTH)`. There is no bypass: when full, `job_ready` stays 0 even in a pop cycle.
  - Pop happens only on the IDLE→XFER… more precisely, on the REQ→XFER transition.
  - Push and pop in the same cycle leave `pending` unchanged. Pointers wrap modulo DEPTH.
- **FSM** (states IDLE, REQ, XFER, GAP; Moore outputs decoded from registered state)
  - IDLE: `req=0`. If `pending != 0` → REQ.
  - REQ: `req=1`. If `gnt==1` → XFER: pop head, load `beat_cnt = job_len(head)`. Otherwise stay in REQ.
  - XFER: `req=1`, `beat_valid=1`, `beat_last = (beat_cnt==0)`.
    - `gnt==1 && beat_cnt!=0`: decrement `beat_cnt`.
    - `gnt==1 && beat_cnt==0`: → GAP.
    - `gnt==0`: set `proto_err`, drop the remaining beats, → GAP.
  - GAP: `req=0` for exactly one cycle so the arbiter sees no request and returns to IDLE; then → IDLE unconditionally.
- `gnt` is ignored in IDLE and GAP; a stale grant there is not an error.
- **Watchdog**
  - `wait_cnt` clears on entry to REQ and increments each REQ cycle with `gnt==0`, saturating.
  - `starve_err` sets on the edge where `wait_cnt==TIMEOUT-1` and `gnt==0`.
  - `req` remains asserted after `starve_err` sets; the FSM is unaffected.
- `starve_err` and `proto_err` clear only on reset.
- **Reset** (asynchronous, any time, including mid-burst)
  - State → IDLE; FIFO emptied and queued jobs discarded; counters cleared.
  - Outputs: `req=0`, `beat_valid=0`, `beat_last=0`, `starve_err=0`, `proto_err=0`, `pending=0`.
  - `job_ready=1` after reset.
- **Arithmetic**
  - `beat_cnt` is LEN_W bits, down-counting, and never underflows (exit at 0).
  - `wait_cnt` is $clog2(TIMEOUT+1) bits.

## Timing
- Job pushed at edge k: `pending=1` after k; state REQ after edge k+1; `req` high in cycle k+1.
- `gnt` sampled high at edge g: `beat_valid` high in cycles g+1 … g+1+len; `pending` decrements after g.
- `req` stays high through the last beat, then is low for the GAP cycle and the IDLE cycle.
- Back-to-back jobs: `req` low for exactly 2 cycles between bursts.
- Minimum latency from job push to first beat: 2 cycles plus arbiter grant latency.

## Test plan
- **Single short burst.** Push `job_len=0` with `gnt` returned 1 cycle after `req` → exactly one `beat_valid` cycle with `beat_last=1`; `req` high for 2 cycles; `pending` goes 1→0.
- **Back-to-back jobs.** Push lengths 2 and 3 back-to-back, with `gnt` tracking `req` after 1 cycle → 3 beats, then `req` low for 2 cycles, then 4 beats. `beat_last` is set only on beats 3 and 7.
- **FIFO full.** Push 5 jobs with `gnt` held 0 → `job_ready` deasserts after the 4th push; `pending=4`; the 5th job is not accepted until the first grant pops an entry.
- **Starvation.** Hold `gnt=0` with one job queued → `starve_err` rises after 16 cycles of `req`; `req` stays 1. Granting later completes the burst with `starve_err` still 1.
- **Grant dropped mid-burst.** Drop `gnt` on beat 2 of a 4-beat burst → `proto_err=1`, `beat_valid` goes 0 the next cycle, GAP then IDLE follow, and the next queued job is serviced normally.
- **Reset mid-burst.** Assert `rst` mid-XFER with 2 jobs pending → all outputs are 0 immediately; `pending=0`; `job_ready=1` after `rst` falls; no `req` until a new job is pushed.
